// File: rtl/wrr_requestor_bank_if.sv
// rtl/wrr_requestor_bank_if.sv - WRR arbitration handshake bundle (req/ack/gnt_w/gnt_id)
interface wrr_requestor_bank_if #(
  parameter int N       = 32,
  parameter int ID_BITS = $clog2(N)
);
  logic [N-1:0]       req;
  logic               ack;
  logic [N-1:0]       gnt_w;
  logic [ID_BITS-1:0] gnt_id;

  // master = requestor bank, slave = arbiter
  modport master (output req, ack, input gnt_w, gnt_id);
  modport slave  (input req, ack, output gnt_w, gnt_id);
endinterface

// File: rtl/wrr_requestor_bank.sv
// rtl/wrr_requestor_bank.sv - per-source pending counters, grant acknowledge FSM and grant protocol checks
module wrr_requestor_bank #(
  parameter int N       = 32,
  parameter int ID_BITS = $clog2(N),
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         push_i,
  wrr_requestor_bank_if.master arb,
  output logic [N-1:0]         full_o,
  output logic                 err_onehot_o,
  output logic                 err_id_o,
  output logic                 err_spurious_o,
  output logic                 err_overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N-1:0]     ONE     = N'(1);

  typedef enum logic {IDLE, ACK} state_e;

  state_e           state_q;
  logic             ack_q;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             err_onehot_q, err_id_q, err_spurious_q, err_overflow_q;
  logic             err_onehot_d, err_id_d, err_spurious_d, err_overflow_d;

  logic [N-1:0] req_w;
  logic [N-1:0] id_mask;
  logic [N-1:0] dec_v;
  logic         grant_v, onehot, id_in_range, id_match, legal;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_w[i]  = (cnt_q[i] != '0);
      full_o[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  assign arb.req = req_w;
  assign arb.ack = ack_q;

  // Grant legality; a shift past N-1 yields zero, so an out-of-range id never matches.
  assign grant_v     = (state_q == IDLE) && (arb.gnt_w != '0);
  assign onehot      = ((arb.gnt_w & (arb.gnt_w - ONE)) == '0);
  assign id_in_range = (32'(arb.gnt_id) < N);
  assign id_mask     = ONE << arb.gnt_id;
  assign id_match    = id_in_range && (arb.gnt_w == id_mask);
  assign legal       = grant_v && onehot && id_match;
  assign dec_v       = legal ? (arb.gnt_w & req_w) : '0;

  assign err_onehot_d   = err_onehot_q | (grant_v && !onehot);
  assign err_id_d       = err_id_q | (grant_v && ((onehot && !id_match) || !id_in_range));
  assign err_spurious_d = err_spurious_q | (legal && ((arb.gnt_w & req_w) == '0));

  // A push coinciding with a decrement cancels out, so it is never dropped even when full.
  always_comb begin
    err_overflow_d = err_overflow_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i]
               + CNT_W'(push_i[i] && !(full_o[i] && !dec_v[i]))
               - CNT_W'(dec_v[i]);
      if (push_i[i] && full_o[i] && !dec_v[i]) begin
        err_overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ack_q          <= 1'b0;
      cnt_q          <= '{default: '0};
      err_onehot_q   <= 1'b0;
      err_id_q       <= 1'b0;
      err_spurious_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb.gnt_w != '0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
      cnt_q          <= cnt_d;
      err_onehot_q   <= err_onehot_d;
      err_id_q       <= err_id_d;
      err_spurious_q <= err_spurious_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_onehot_o   = err_onehot_q;
  assign err_id_o       = err_id_q;
  assign err_spurious_o = err_spurious_q;
  assign err_overflow_o = err_overflow_q;

endmodule

// File: tb/tb_wrr_requestor_bank.sv
// tb/tb_wrr_requestor_bank.sv - directed and randomized checks of wrr_requestor_bank against a count model
module tb_wrr_requestor_bank;
  localparam int N       = 4;
  localparam int ID_BITS = 2;
  localparam int CNT_W   = 2;
  localparam int MAXC    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] push;
  logic [3:0] full;
  logic       e_oh, e_id, e_sp, e_ov;

  always #5 clk = ~clk;

  wrr_requestor_bank_if #(.N(N), .ID_BITS(ID_BITS)) bus ();

  wrr_requestor_bank #(.N(N), .ID_BITS(ID_BITS), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .arb            (bus),
    .full_o         (full),
    .err_onehot_o   (e_oh),
    .err_id_o       (e_id),
    .err_spurious_o (e_sp),
    .err_overflow_o (e_ov)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain integer counts plus "an ack is outstanding" flag
  int m_cnt [4];
  bit m_ack;
  bit m_oh, m_id, m_sp, m_ov;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_req();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_cnt[i] == MAXC);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ack = 0; m_oh = 0; m_id = 0; m_sp = 0; m_ov = 0;
  endtask

  task automatic model_step();
    int  taken;
    int  ones;
    int  idx;
    bit  nxt_ack;
    taken   = -1;
    nxt_ack = 0;
    if (!m_ack && bus.gnt_w != 0) begin
      nxt_ack = 1;
      ones = 0;
      idx  = -1;
      for (int i = 0; i < 4; i++) if (bus.gnt_w[i]) begin ones++; idx = i; end
      if (ones != 1)                 m_oh = 1;
      else if (idx != int'(bus.gnt_id)) m_id = 1;
      else if (m_cnt[idx] == 0)      m_sp = 1;
      else                           taken = idx;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == taken) begin
        if (!push[i]) m_cnt[i]--;
      end else if (push[i]) begin
        if (m_cnt[i] == MAXC) m_ov = 1;
        else m_cnt[i]++;
      end
    end
    m_ack = nxt_ack;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".ack"},  32'(bus.ack), 32'(m_ack));
    check_eq({tag, ".req"},  32'(bus.req), 32'(m_req()));
    check_eq({tag, ".full"}, 32'(full),    32'(m_full()));
    check_eq({tag, ".eoh"},  32'(e_oh),    32'(m_oh));
    check_eq({tag, ".eid"},  32'(e_id),    32'(m_id));
    check_eq({tag, ".esp"},  32'(e_sp),    32'(m_sp));
    check_eq({tag, ".eov"},  32'(e_ov),    32'(m_ov));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic [3:0] p, input logic [3:0] gw, input logic [1:0] gid);
    push       = p;
    bus.gnt_w  = gw;
    bus.gnt_id = gid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    compare_all("reset");
  endtask

  initial begin
    logic [3:0] gw;
    int r;
    int id;
    model_clear();
    do_reset();

    // 1: single push then legal grant
    drive(4'b0010, 4'b0000, 2'd0); tick("t1push");
    check_eq("t1.req_after_push", 32'(bus.req), 32'h2);
    drive(4'b0000, 4'b0010, 2'd1); tick("t1gnt");
    check_eq("t1.ack", 32'(bus.ack), 32'h1);
    check_eq("t1.req_drop", 32'(bus.req), 32'h0);
    drive(4'b0000, 4'b0000, 2'd0); tick("t1idle");

    // 2: four pushes into source 0, then three grants
    for (int k = 0; k < 4; k++) begin drive(4'b0001, 4'b0000, 2'd0); tick("t2push"); end
    check_eq("t2.full0", 32'(full[0]), 32'h1);
    check_eq("t2.ovf", 32'(e_ov), 32'h1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 4'b0001, 2'd0); tick("t2gnt");
      check_eq("t2.ack", 32'(bus.ack), 32'h1);
      drive(4'b0000, 4'b0000, 2'd0); tick("t2gap");
    end
    check_eq("t2.req0_drop", 32'(bus.req[0]), 32'h0);

    // 3: held grant with cnt[0]=2
    do_reset();
    for (int k = 0; k < 2; k++) begin drive(4'b0001, 4'b0000, 2'd0); tick("t3push"); end
    drive(4'b0000, 4'b0001, 2'd0);
    tick("t3h0"); check_eq("t3.ack0", 32'(bus.ack), 32'h1);
    tick("t3h1"); check_eq("t3.ack1", 32'(bus.ack), 32'h0);
    tick("t3h2"); check_eq("t3.ack2", 32'(bus.ack), 32'h1);
    check_eq("t3.req0", 32'(bus.req[0]), 32'h0);
    drive(4'b0000, 4'b0000, 2'd0); tick("t3idle");

    // 4: illegal grants
    do_reset();
    drive(4'b0010, 4'b0000, 2'd0); tick("t4push");
    drive(4'b0000, 4'b0110, 2'd1); tick("t4oh");
    drive(4'b0000, 4'b0000, 2'd0); tick("t4gap");
    drive(4'b0000, 4'b0100, 2'd1); tick("t4id");
    drive(4'b0000, 4'b0000, 2'd0); tick("t4gap");
    drive(4'b0000, 4'b1000, 2'd3); tick("t4sp");
    check_eq("t4.ack", 32'(bus.ack), 32'h1);
    drive(4'b0000, 4'b0000, 2'd0); tick("t4idle");
    check_eq("t4.errs", 32'({e_oh, e_id, e_sp, e_ov}), 32'b1110);
    check_eq("t4.req", 32'(bus.req), 32'h2);

    // 5: push to a full counter alongside a legal grant to it
    do_reset();
    for (int k = 0; k < 3; k++) begin drive(4'b0100, 4'b0000, 2'd0); tick("t5push"); end
    drive(4'b0100, 4'b0100, 2'd2); tick("t5both");
    check_eq("t5.full2", 32'(full[2]), 32'h1);
    check_eq("t5.ovf", 32'(e_ov), 32'h0);
    drive(4'b0000, 4'b0000, 2'd0); tick("t5idle");

    // 6: async reset during ACK
    do_reset();
    for (int k = 0; k < 3; k++) begin drive(4'b0011, 4'b0000, 2'd0); tick("t6push"); end
    drive(4'b0011, 4'b0000, 2'd0); tick("t6ovf");
    drive(4'b0000, 4'b0001, 2'd0); tick("t6gnt");
    check_eq("t6.ack_before", 32'(bus.ack), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6.ack_async", 32'(bus.ack), 32'h0);
    check_eq("t6.req_async", 32'(bus.req), 32'h0);
    check_eq("t6.full_async", 32'(full), 32'h0);
    check_eq("t6.err_async", 32'({e_oh, e_id, e_sp, e_ov}), 32'h0);
    model_clear();
    drive(4'b0000, 4'b0000, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(4'b0000, 4'b0001, 2'd0); tick("t6spur");
    check_eq("t6.esp", 32'(e_sp), 32'h1);
    drive(4'b0000, 4'b0000, 2'd0); tick("t6idle");

    // randomized segments; illegal grants only in the last one
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < 4; i++) push[i] = ($urandom_range(0, 2 - (seg == 1 ? 1 : 0)) == 0);
        r  = $urandom_range(0, 9);
        id = $urandom_range(0, 3);
        if (r < 5) begin
          gw = 4'b0001 << id;
          bus.gnt_w  = gw;
          bus.gnt_id = 2'(id);
        end else if (r == 5 && seg == 2) begin
          bus.gnt_w  = 4'($urandom_range(1, 15));
          bus.gnt_id = 2'($urandom_range(0, 3));
        end else begin
          bus.gnt_w  = 4'b0000;
          bus.gnt_id = 2'(id);
        end
        tick("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wrr_requestor_bank.md
# wrr_requestor_bank

Requestor-side endpoint of the weighted round-robin arbitration interface (`req`, `ack`, `gnt_w`, `gnt_id`). It holds a saturating pending-request counter per source, drives `req` while work is pending, and consumes arbiter grants by pulsing `ack`. It also checks every grant for protocol errors. It sits between N request sources and the WRR arbiter, and also serves as the reference DUT driving the arbiter in block-level benches.

## Interface

**Parameters**

- `N`, default 32: number of requestors.
- `ID_BITS`, default `$clog2(N)`: width of `gnt_id`.
- `CNT_W`, default 4: width of each pending counter; maximum value is 2^CNT_W-1.

**Ports**

- `clk` in, 1: single clock; all logic is rising-edge.
- `rst` in, 1: asynchronous, active-high reset.
- `push` in, N: per-source pulse that adds one pending request.
- `req` out, N: `req[i]` = (`cnt[i]` != 0), decoded directly from registers.
- `ack` out, 1: one-cycle grant acknowledge.
- `gnt_w` in, N: one-hot grant vector from the arbiter; all-zero means no grant.
- `gnt_id` in, ID_BITS: binary index of the granted requestor.
- `full` out, N: `full[i]` = (`cnt[i]` == max).
- `err_onehot` out, 1: sticky; set when `gnt_w` is nonzero and not one-hot.
- `err_id` out, 1: sticky; set when `gnt_w` is one-hot but its bit index ≠ `gnt_id`, or when `gnt_id` ≥ N.
- `err_spurious` out, 1: sticky; set on a legal grant to a source with `cnt` == 0.
- `err_overflow` out, 1: sticky; set when a push arrives at a full counter with no same-cycle decrement.

## Operation

- **Reset** clears all `cnt`, the FSM goes to IDLE, and all outputs are 0: `req`=0, `ack`=0, `full`=0, all `err_*`=0.
- **Counters:** per cycle, `cnt[i]` next = `cnt[i]` + `inc[i]` − `dec[i]`.
  - `inc[i]` = `push[i]` && !(`full[i]` && !`dec[i]`).
  - A push and a grant-decrement to the same index in the same cycle leave the count unchanged. This holds even when the counter is full; no overflow flag is set in that case.
  - A dropped push sets `err_overflow`.
- **FSM has two states:**
  - IDLE:
    - If `gnt_w` == 0, stay in IDLE with `ack`=0.
    - Otherwise, at the edge: `ack` <= 1, go to ACK.
    - If the grant is legal (one-hot, index == `gnt_id`, `gnt_id` < N) and `cnt[gnt_id]` != 0, `dec[gnt_id]`=1 at that same edge.
    - An illegal grant sets the matching `err_*`; there is no decrement, but `ack` is still pulsed so the arbiter never deadlocks.
    - A legal grant with zero count sets `err_spurious`, pulses `ack`, and does not decrement.
  - ACK: `ack` is 1 for exactly this cycle. `gnt_w` and `gnt_id` are ignored. Next state is IDLE and `ack` <= 0.
- **Arbiter contract:** the arbiter holds the grant until it samples `ack`=1, then deasserts or changes the grant in the following cycle. A grant still present when the block returns to IDLE is treated as a new grant.
- Error flags clear only on `rst`.

## Timing

- A grant present in IDLE cycle T produces `ack`=1 in T+1 and the count decrement visible in T+1. `req[i]` falls in T+1 if the count reached 0.
- Maximum grant throughput is one per 2 cycles.
- A push in cycle T makes `req[i]`=1 in T+1. The request-to-`req` latency is 1 cycle.
- `full` and `req` are functions of registered counts only, with no combinational path from inputs.
- `err_*` rise in the cycle after the offending grant or push.
- Asserting `rst` mid-ACK forces `ack`=0 immediately (asynchronously) and discards all pending counts.

## Test plan

Benches use N=4, CNT_W=2 (max 3).

1. Push `push`=4'b0010 for 1 cycle → `req`=0010 the next cycle. Then `gnt_w`=0010, `gnt_id`=1 → `ack` pulses 1 cycle later, `req`=0000 in the same cycle, and no `err_*` is set.
2. Push source 0 four times in consecutive cycles → `cnt[0]`=3, `full[0]`=1, `err_overflow`=1. Then three legal grants to 0 → three `ack` pulses 2 cycles apart, and `req[0]` drops after the third.
3. Hold `gnt_w`=0001 with `gnt_id`=0 for 3 cycles with `cnt[0]`=2 → `ack` pattern is 0,1,0 then 1 on the re-grant, and the count decrements twice to 0.
4. Issue `gnt_w`=0110; then `gnt_w`=0100 with `gnt_id`=1; then `gnt_w`=1000 with `gnt_id`=3 and `cnt[3]`=0 → `err_onehot`, `err_id`, and `err_spurious` each set. Every grant gets `ack`, and no counts change.
5. With `cnt[2]`=3, drive `push[2]` in the same cycle as a legal grant to 2 → `cnt[2]` stays 3 and `err_overflow` stays 0.
6. Assert `rst` during the ACK cycle → `ack`, `req`, `full`, and all `err_*` go to 0 asynchronously. After release, a grant with no pending work sets `err_spurious`.
